// File: rtl/or3_mon_pkg.sv
// Shared types and constants for the OR3X1 toggle monitor.
package or3_mon_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } mon_state_e;

  // All-ones value of a w-bit counter, used as the saturation ceiling.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/or3_mon_sync.sv
// Two-flop synchroniser for the asynchronous OR3X1 Q output.
// Optional glitch filter enabled by defining OR3_MON_GLITCH_FILTER_EN.
module or3_mon_sync (
  input  logic CLK,
  input  logic RSTB,
  input  logic Q_IN,
  output logic S
);

  logic ff1;
  logic ff2;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
    end else begin
      ff1 <= Q_IN;
      ff2 <= ff1;
    end
  end

`ifdef OR3_MON_GLITCH_FILTER_EN
  logic ff3;
  logic s_hold;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      ff3    <= 1'b0;
      s_hold <= 1'b0;
    end else begin
      ff3    <= ff2;
      s_hold <= S;
    end
  end

  // Accept a new level only once two consecutive synchronised samples agree;
  // the combinational pass keeps the added latency to a single cycle.
  assign S = (ff2 == ff3) ? ff2 : s_hold;
`else
  assign S = ff2;
`endif

endmodule

// File: rtl/or3_toggle_monitor.sv
// Counts rising/falling edges and high cycles of OR3X1 Q over a window,
// presenting the result on a valid/ready port. Filter: OR3_MON_GLITCH_FILTER_EN.
module or3_toggle_monitor
  import or3_mon_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             Q_IN,
  input  logic [WIN_W-1:0] WIN_LEN,
  input  logic             START,
  output logic             BUSY,
  output logic [CNT_W-1:0] RISE_CNT,
  output logic [CNT_W-1:0] FALL_CNT,
  output logic [CNT_W-1:0] HIGH_CNT,
  output logic             RES_VALID,
  input  logic             RES_READY
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  mon_state_e       state;
  logic [WIN_W-1:0] win_cnt;
  logic             s;
  logic             p;
  logic [CNT_W-1:0] rise_q;
  logic [CNT_W-1:0] fall_q;
  logic [CNT_W-1:0] high_q;

  or3_mon_sync u_sync (
    .CLK  (CLK),
    .RSTB (RSTB),
    .Q_IN (Q_IN),
    .S    (s)
  );

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state   <= IDLE;
      win_cnt <= '0;
      p       <= 1'b0;
      rise_q  <= '0;
      fall_q  <= '0;
      high_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START && (WIN_LEN != '0)) begin
            state   <= RUN;
            win_cnt <= WIN_LEN;
            p       <= s;
            rise_q  <= '0;
            fall_q  <= '0;
            high_q  <= '0;
          end
        end
        RUN: begin
          p       <= s;
          win_cnt <= win_cnt - WIN_W'(1);
          if (s && !p && (rise_q != CNT_MAX)) rise_q <= rise_q + CNT_W'(1);
          if (!s && p && (fall_q != CNT_MAX)) fall_q <= fall_q + CNT_W'(1);
          if (s && (high_q != CNT_MAX))       high_q <= high_q + CNT_W'(1);
          // The edge that consumes the last window cycle is also the HOLD entry.
          if (win_cnt == WIN_W'(1)) state <= HOLD;
        end
        HOLD: begin
          if (RES_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY      = (state != IDLE);
  assign RES_VALID = (state == HOLD);
  assign RISE_CNT  = rise_q;
  assign FALL_CNT  = fall_q;
  assign HIGH_CNT  = high_q;

endmodule

// File: tb/tb_or3_toggle_monitor.sv
// Self-checking bench for or3_toggle_monitor: window-level reference model
// plus directed literal checks, run against a 16-bit and a 4-bit counter build.
module tb_or3_toggle_monitor;

  logic        CLK = 1'b0;
  logic        RSTB = 1'b0;
  logic        Q_IN = 1'b0;
  logic [15:0] WIN_LEN = '0;
  logic        START = 1'b0;
  logic        RES_READY = 1'b0;

  logic        busy_a, valid_a;
  logic [15:0] rise_a, fall_a, high_a;
  logic        busy_b, valid_b;
  logic [3:0]  rise_b, fall_b, high_b;

  int n_cmp = 0;
  int n_bad = 0;

  or3_toggle_monitor #(.CNT_W(16), .WIN_W(16)) dut (
    .CLK(CLK), .RSTB(RSTB), .Q_IN(Q_IN), .WIN_LEN(WIN_LEN), .START(START),
    .BUSY(busy_a), .RISE_CNT(rise_a), .FALL_CNT(fall_a), .HIGH_CNT(high_a),
    .RES_VALID(valid_a), .RES_READY(RES_READY)
  );

  or3_toggle_monitor #(.CNT_W(4), .WIN_W(16)) dut4 (
    .CLK(CLK), .RSTB(RSTB), .Q_IN(Q_IN), .WIN_LEN(WIN_LEN), .START(START),
    .BUSY(busy_b), .RISE_CNT(rise_b), .FALL_CNT(fall_b), .HIGH_CNT(high_b),
    .RES_VALID(valid_b), .RES_READY(RES_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Q_IN pattern driver ----------------
  int qmode = 0;
  bit qconst = 1'b0;
  int qph = 0;

  always @(posedge CLK) begin
    #1;
    qph++;
    case (qmode)
      0: Q_IN = qconst;
      1: Q_IN = ((qph / 2) % 2) != 0;
      2: Q_IN = (qph % 2) != 0;
      3: Q_IN = (qph % 6) == 0;
      default: Q_IN = $urandom_range(0, 1) != 0;
    endcase
  end

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 window open, 2 result held. m_win[0] is the sample at
  // window start, followed by one synchronised sample per window cycle.
  int m_mode = 0;
  int m_rem = 0;
  bit m_win[$];
  bit m_s = 1'b0, m_q1 = 1'b0, m_q2 = 1'b0;

  always @(posedge CLK) begin
    bit ns;
    if (!RSTB) begin
      m_mode = 0;
      m_rem  = 0;
      m_win.delete();
      m_s = 1'b0; m_q1 = 1'b0; m_q2 = 1'b0;
    end else begin
      case (m_mode)
        0: if (START && WIN_LEN != 0) begin
             m_mode = 1;
             m_rem  = WIN_LEN;
             m_win.delete();
             m_win.push_back(m_s);
           end
        1: begin
             m_win.push_back(m_s);
             m_rem--;
             if (m_rem == 0) m_mode = 2;
           end
        default: if (RES_READY) m_mode = 0;
      endcase
`ifdef OR3_MON_GLITCH_FILTER_EN
      ns = (m_q1 == m_q2) ? m_q1 : m_s;
`else
      ns = m_q1;
`endif
      m_q2 = m_q1;
      m_q1 = Q_IN;
      m_s  = ns;
    end
  end

  function automatic int win_rise();
    int n = 0;
    for (int i = 1; i < m_win.size(); i++) if (m_win[i] && !m_win[i-1]) n++;
    return n;
  endfunction

  function automatic int win_fall();
    int n = 0;
    for (int i = 1; i < m_win.size(); i++) if (!m_win[i] && m_win[i-1]) n++;
    return n;
  endfunction

  function automatic int win_high();
    int n = 0;
    for (int i = 1; i < m_win.size(); i++) if (m_win[i]) n++;
    return n;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    int er, ef, eh, eb, ev;
    if (!RSTB) begin
      er = 0; ef = 0; eh = 0; eb = 0; ev = 0;
    end else begin
      er = win_rise(); ef = win_fall(); eh = win_high();
      eb = (m_mode != 0) ? 1 : 0;
      ev = (m_mode == 2) ? 1 : 0;
    end
    chk("busy16",  busy_a,  eb);
    chk("valid16", valid_a, ev);
    chk("rise16",  rise_a,  sat(er, 65535));
    chk("fall16",  fall_a,  sat(ef, 65535));
    chk("high16",  high_a,  sat(eh, 65535));
    chk("busy4",   busy_b,  eb);
    chk("valid4",  valid_b, ev);
    chk("rise4",   rise_b,  sat(er, 15));
    chk("fall4",   fall_b,  sat(ef, 15));
    chk("high4",   high_b,  sat(eh, 15));
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Issues START now; returns the edge count (START edge = 1) at which
  // RES_VALID is first seen, or -1 if the bound expires.
  task automatic start_and_wait(input int len, output int edges);
    WIN_LEN = 16'(len);
    START = 1'b1;
    edges = -1;
    for (int n = 1; n <= 200; n++) begin
      step(1);
      START = 1'b0;
      if (valid_a) begin
        edges = n;
        break;
      end
    end
    if (edges < 0) chk("valid_timeout", 0, 1);
  endtask

  task automatic release_result();
    RES_READY = 1'b1;
    step(1);
    RES_READY = 1'b0;
    step(1);
  endtask

  initial begin
    int e;
    logic [15:0] hr, hf, hh;

    step(3);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_rise", rise_a, 0);
    RSTB = 1'b1;
    step(2);

    // Constant high: no edges, every window cycle counts as high.
    qmode = 0; qconst = 1'b1;
    step(5);
    start_and_wait(8, e);
    chk("const_edges", e, 9);
    chk("const_rise", rise_a, 0);
    chk("const_fall", fall_a, 0);
    chk("const_high", high_a, 8);
    release_result();

    // Toggle every 2 cycles over 20 cycles: 5 of each edge, 10 high.
    qmode = 1;
    step(4);
    start_and_wait(20, e);
    chk("tog_edges", e, 21);
    chk("tog_rise", rise_a, 5);
    chk("tog_fall", fall_a, 5);
    chk("tog_high", high_a, 10);

    // Handshake stall, START in HOLD ignored, then release.
    hr = rise_a; hf = fall_a; hh = high_a;
    for (int i = 0; i < 5; i++) begin
      START = (i == 2);
      WIN_LEN = 16'd5;
      step(1);
      chk("hold_busy", busy_a, 1);
      chk("hold_valid", valid_a, 1);
      chk("hold_rise", rise_a, hr);
      chk("hold_fall", fall_a, hf);
      chk("hold_high", high_a, hh);
    end
    START = 1'b0;
    RES_READY = 1'b1;
    step(1);
    RES_READY = 1'b0;
    chk("rel_busy", busy_a, 0);
    chk("rel_valid", valid_a, 0);
    chk("idle_keep", rise_a, hr);
    step(1);

    // Toggle every cycle for 40 cycles: 4-bit build saturates.
    qmode = 2;
    step(3);
    start_and_wait(40, e);
    chk("sat_edges", e, 41);
`ifdef OR3_MON_GLITCH_FILTER_EN
    chk("sat_rise4", rise_b, 0);
    chk("sat_fall4", fall_b, 0);
    chk("sat_rise16", rise_a, 0);
`else
    chk("sat_rise4", rise_b, 15);
    chk("sat_fall4", fall_b, 15);
    chk("sat_high4", high_b, 15);
    chk("sat_rise16", rise_a, 20);
    chk("sat_fall16", fall_a, 20);
`endif
    release_result();

    // Zero-length window is ignored.
    WIN_LEN = 16'd0;
    START = 1'b1;
    step(1);
    START = 1'b0;
    chk("zero_busy", busy_a, 0);
    step(1);
    chk("zero_busy2", busy_a, 0);

    // One-cycle pulses every 6 cycles over 30 cycles.
    qmode = 3;
    step(3);
    start_and_wait(30, e);
`ifdef OR3_MON_GLITCH_FILTER_EN
    chk("glitch_rise", rise_a, 0);
    chk("glitch_fall", fall_a, 0);
    chk("glitch_high", high_a, 0);
`else
    chk("glitch_rise", rise_a, 5);
    chk("glitch_high", high_a, 5);
`endif
    release_result();

    // Reset mid-window aborts with no result.
    qmode = 1;
    WIN_LEN = 16'd10;
    START = 1'b1;
    step(1);
    START = 1'b0;
    step(3);
    chk("mid_busy_pre", busy_a, 1);
    RSTB = 1'b0;
    #1;
    chk("mid_busy", busy_a, 0);
    chk("mid_valid", valid_a, 0);
    chk("mid_rise", rise_a, 0);
    chk("mid_high", high_a, 0);
    step(2);
    RSTB = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk("mid_novalid", valid_a, 0);
    end

    // Random traffic.
    qmode = 4;
    for (int i = 0; i < 2500; i++) begin
      START = ($urandom_range(0, 7) == 0);
      WIN_LEN = 16'($urandom_range(0, 40));
      RES_READY = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 399) == 0) begin
        RSTB = 1'b0;
        step(2);
        RSTB = 1'b1;
      end
      step(1);
    end
    START = 1'b0;
    RES_READY = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
